// File: rtl/note_sequencer_pkg.sv
// Shared types for the note sequencer: FSM state encoding and ROM duration field width.
package note_sequencer_pkg;

  localparam int DUR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // A zero duration field still plays one beat.
  function automatic logic [DUR_W-1:0] dur_beats(input logic [DUR_W-1:0] raw);
    return (raw == '0) ? DUR_W'(1) : raw;
  endfunction

endpackage

// File: rtl/note_sequencer_beat_timer.sv
// Per-note beat timer: tick_cnt runs 0..BEAT_DIV-1, dur_cnt counts remaining beats.
// Holds its count whenever en is low; note_end marks the last tick of the last beat.
module note_sequencer_beat_timer
  import note_sequencer_pkg::*;
#(
  parameter int BEAT_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [DUR_W-1:0] dur_in,
  output logic             note_end
);

  localparam int TICK_W = $clog2(BEAT_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic [DUR_W-1:0]  dur_cnt;
  logic              tick_wrap;

  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign note_end  = en && tick_wrap && (dur_cnt == DUR_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else if (load) begin
      tick_cnt <= '0;
      dur_cnt  <= dur_beats(dur_in);
    end else if (en) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        dur_cnt  <= dur_cnt - DUR_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks the music ROM, times each note and the silent gap after it,
// and requests address increments from the downstream incrementer during the gap.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | stopped, addr=0, waiting for play
//   ST_LOAD  | one cycle for ROM data; beat timer loads the note duration
//   ST_PLAY  | note sounding (note_valid=1), beat timer running
//   ST_PAUSE | note frozen and silent until pause drops
//   ST_GAP   | silent gap, area=1 so next_addr=addr+1 is ready at gap end
//   ST_DONE  | last note finished without looping (song_done=1)
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int BEAT_DIV = 25_000_000,
  parameter int GAP_CYC  = 1_000_000,
  parameter int SONG_LEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play,
  input  logic             pause,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [DUR_W-1:0] rom_dur,
  input  logic [15:0]      next_addr,
  output logic [15:0]      addr,
  output logic             area,
  output logic             note_valid,
  output logic             song_done
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [15:0]      LAST_ADDR = 16'(SONG_LEN - 1);

  state_t           state, state_nxt;
  logic [15:0]      addr_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             note_end;

  note_sequencer_beat_timer #(.BEAT_DIV(BEAT_DIV)) u_beat_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (stop),
    .load     (state == ST_LOAD),
    .en       (state == ST_PLAY),
    .dur_in   (rom_dur),
    .note_end (note_end)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    gap_nxt   = gap_cnt;
    if (stop) begin
      state_nxt = ST_IDLE;
      addr_nxt  = '0;
      gap_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (play && !pause) begin
            state_nxt = ST_LOAD;
            addr_nxt  = '0;
          end
        end
        ST_LOAD: state_nxt = ST_PLAY;
        ST_PLAY: begin
          // A note that finishes on the same cycle pause arrives still moves on to its gap.
          if (note_end) begin
            state_nxt = ST_GAP;
            gap_nxt   = '0;
          end else if (pause) begin
            state_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!pause) state_nxt = ST_PLAY;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_nxt = '0;
            if (addr != LAST_ADDR) begin
              state_nxt = ST_LOAD;
              addr_nxt  = next_addr;
            end else if (loop_en) begin
              state_nxt = ST_LOAD;
              addr_nxt  = '0;
            end else begin
              state_nxt = ST_DONE;
            end
          end else begin
            gap_nxt = gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          addr_nxt  = '0;
          gap_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  assign note_valid = (state == ST_PLAY);
  assign area       = (state == ST_GAP);
  assign song_done  = (state == ST_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed song scenarios followed by random control traffic,
// all checked each cycle against a remaining-cycles behavioural model of the player.
module tb_note_sequencer;

  localparam int BEAT_DIV = 4;
  localparam int GAP_CYC  = 2;
  localparam int SONG_LEN = 3;

  logic        clk = 1'b0;
  logic        rst, play, pause, stop, loop_en;
  logic [3:0]  rom_dur;
  logic [15:0] next_addr, addr;
  logic        area, note_valid, song_done;

  logic [3:0]  rom_tab [SONG_LEN];

  int vectors = 0;
  int miscompares = 0;

  typedef enum {M_IDLE, M_FETCH, M_SOUND, M_HOLD, M_GAP, M_END} mmode_t;
  mmode_t m_mode;
  int     m_addr, m_sound_left, m_gap_left;

  always #5 clk = ~clk;

  assign rom_dur   = (addr < 16'(SONG_LEN)) ? rom_tab[addr[1:0]] : 4'd0;
  assign next_addr = area ? addr + 16'd1 : addr;

  note_sequencer #(.BEAT_DIV(BEAT_DIV), .GAP_CYC(GAP_CYC), .SONG_LEN(SONG_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .play       (play),
    .pause      (pause),
    .stop       (stop),
    .loop_en    (loop_en),
    .rom_dur    (rom_dur),
    .next_addr  (next_addr),
    .addr       (addr),
    .area       (area),
    .note_valid (note_valid),
    .song_done  (song_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Player behaviour in terms of cycles left to sound / stay silent.
  task automatic model_step();
    int beats;
    if (rst || stop) begin
      m_mode = M_IDLE;
      m_addr = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_END: if (play && !pause) begin m_mode = M_FETCH; m_addr = 0; end
        M_FETCH: begin
          beats = (rom_tab[m_addr] == 4'd0) ? 1 : int'(rom_tab[m_addr]);
          m_sound_left = beats * BEAT_DIV;
          m_mode = M_SOUND;
        end
        M_SOUND: begin
          m_sound_left--;
          if (m_sound_left == 0) begin m_mode = M_GAP; m_gap_left = GAP_CYC; end
          else if (pause) m_mode = M_HOLD;
        end
        M_HOLD: if (!pause) m_mode = M_SOUND;
        M_GAP: begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            if (m_addr != SONG_LEN - 1) begin m_addr++; m_mode = M_FETCH; end
            else if (loop_en) begin m_addr = 0; m_mode = M_FETCH; end
            else m_mode = M_END;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("addr", 32'(addr), 32'(m_addr));
    chk("note_valid", 32'(note_valid), 32'(m_mode == M_SOUND));
    chk("area", 32'(area), 32'(m_mode == M_GAP));
    chk("song_done", 32'(song_done), 32'(m_mode == M_END));
  endtask

  task automatic wait_sound(input int limit);
    int n = 0;
    while (note_valid !== 1'b1 && n < limit) begin cyc(); n++; end
    if (note_valid !== 1'b1) chk("wait_sound_timeout", 32'(note_valid), 32'd1);
  endtask

  task automatic count_sound(output int n);
    n = 0;
    while (note_valid === 1'b1 && n < 100) begin n++; cyc(); end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (song_done !== 1'b1 && n < limit) begin cyc(); n++; end
    if (song_done !== 1'b1) chk("wait_done_timeout", 32'(song_done), 32'd1);
  endtask

  task automatic pulse_play();
    play = 1'b1; cyc(); play = 1'b0;
  endtask

  initial begin
    int n;
    rom_tab[0] = 4'd2; rom_tab[1] = 4'd1; rom_tab[2] = 4'd0;
    rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
    m_mode = M_IDLE; m_addr = 0; m_sound_left = 0; m_gap_left = 0;

    // Reset held for three cycles.
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Full song without looping: 8, 4, 4 sounding cycles, then done at addr 2.
    pulse_play();
    wait_sound(10); count_sound(n); chk("note0_len", 32'(n), 32'd8);
    wait_sound(10); count_sound(n); chk("note1_len", 32'(n), 32'd4);
    wait_sound(10); count_sound(n); chk("note2_len", 32'(n), 32'd4);
    wait_done(10);
    chk("done_addr", 32'(addr), 32'd2);

    // Looping: after the addr-2 gap the song restarts at addr 0.
    loop_en = 1'b1;
    pulse_play();
    repeat (3) begin wait_sound(10); count_sound(n); end
    wait_sound(10);
    chk("loop_addr", 32'(addr), 32'd0);
    count_sound(n); chk("loop_note0_len", 32'(n), 32'd8);
    stop = 1'b1; cyc(); stop = 1'b0; cyc();

    // Pause for 10 cycles after the third sounding cycle of note 0.
    pulse_play();
    wait_sound(10); cyc(); cyc();
    pause = 1'b1;
    repeat (10) begin
      cyc();
      chk("pause_silent", 32'(note_valid), 32'd0);
      chk("pause_addr", 32'(addr), 32'd0);
    end
    pause = 1'b0;
    cyc();
    count_sound(n); chk("resume_len", 32'(n), 32'd5);

    // Stop during the gap after note 1.
    wait_sound(10); count_sound(n); chk("note1_len_b", 32'(n), 32'd4);
    chk("in_gap", 32'(area), 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_addr", 32'(addr), 32'd0);
    chk("stop_area", 32'(area), 32'd0);
    repeat (30) begin cyc(); chk("never_addr2", 32'(addr == 16'd2), 32'd0); end

    // play and stop together in DONE: stop wins.
    loop_en = 1'b0;
    pulse_play();
    wait_done(60);
    play = 1'b1; stop = 1'b1; cyc(); play = 1'b0; stop = 1'b0;
    chk("stop_wins_done", 32'(song_done), 32'd0);
    chk("stop_wins_valid", 32'(note_valid), 32'd0);
    repeat (3) cyc();

    // Random control traffic with a random ROM image.
    for (int i = 0; i < SONG_LEN; i++)
      rom_tab[i] = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      play  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 14) == 0) pause = ~pause;
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
